// File: rtl/lsu_axi_if.sv
// lsu_axi_if -- bundle of every handshake/bus signal around the load/store unit.
//
// Groups the execute-stage request/response pair together with the five
// AXI-lite channels so the LSU and its environment connect through a single
// port.
//   master : the LSU side (accepts requests, drives AXI address/data/ready)
//   slave  : the environment side (issues requests, plays the AXI slave)
// Signal summary:
//   req_valid/req_ready/req_wen/req_memop[2:0]/req_addr[63:0]/req_wdata[63:0]
//   resp_valid/resp_rdata[63:0]/resp_err
//   AW: AWADDR[63:0]/AWVALID/AWREADY   W: WDATA[63:0]/WSTRB[7:0]/WVALID/WREADY
//   B : BVALID/BRESP[1:0]/BREADY       AR: ARADDR[63:0]/ARVALID/ARREADY
//   R : RDATA[63:0]/RRESP[1:0]/RVALID/RREADY
`timescale 1ns/1ps
interface lsu_axi_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_memop;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic        BVALID;
  logic [1:0]  BRESP;
  logic        BREADY;
  logic [63:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  modport master (
    input  req_valid, req_wen, req_memop, req_addr, req_wdata,
           AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RRESP, RVALID,
    output req_ready, resp_valid, resp_rdata, resp_err,
           AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY
  );

  modport slave (
    output req_valid, req_wen, req_memop, req_addr, req_wdata,
           AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RRESP, RVALID,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY
  );
endinterface

// File: rtl/lsu_axi.sv
// lsu_axi -- single-outstanding load/store unit with an AXI-lite master port.
//
// Accepts one request from the execute stage at a time, performs it as one
// 64-bit AXI-lite beat on the doubleword containing the address, and returns
// a one-cycle completion pulse with sign/zero-extended load data.
// Ports:
//   clk  : core clock, all state updates on its rising edge
//   rst  : synchronous active-high reset, abandons any transaction
//   bus  : lsu_axi_if.master (request/response plus AW/W/B/AR/R channels)
// Build option:
//   LSU_MISALIGN_CHECK_EN -- when defined, h/w/d accesses that are not
//   naturally aligned complete immediately with resp_err=1 and never reach
//   the bus; otherwise they are issued with strobe/data truncated to 8 bytes.
`timescale 1ns/1ps
module lsu_axi (
  input logic        clk,
  input logic        rst,
  lsu_axi_if.master  bus
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, RESP} state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic [2:0]  memop_q, memop_d;
  logic        wen_q, wen_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        err_q, err_d;

  logic [63:0] rd_shifted;
  logic [63:0] load_ext;
  logic [7:0]  strb_base;
  logic        aw_fire;
  logic        w_fire;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      memop_q   <= '0;
      wen_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      memop_q   <= memop_d;
      wen_q     <= wen_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

  // Lane alignment: the bus always moves the whole doubleword, so loads
  // shift the addressed byte down to bit 0 and extend from the access size;
  // stores shift data and a size-wide strobe up to the byte offset.
  always_comb begin
    rd_shifted = bus.RDATA >> {addr_q[2:0], 3'b000};
    case (memop_q[1:0])
      2'b00:   load_ext = {{56{~memop_q[2] & rd_shifted[7]}},  rd_shifted[7:0]};
      2'b01:   load_ext = {{48{~memop_q[2] & rd_shifted[15]}}, rd_shifted[15:0]};
      2'b10:   load_ext = {{32{~memop_q[2] & rd_shifted[31]}}, rd_shifted[31:0]};
      default: load_ext = rd_shifted;
    endcase
    case (memop_q[1:0])
      2'b00:   strb_base = 8'h01;
      2'b01:   strb_base = 8'h03;
      2'b10:   strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    case (bus.req_memop[1:0])
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      2'b11:   misaligned = |bus.req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end
`endif

  // Next state and datapath capture. AW and W are tracked by separate done
  // flags so either may complete first; both completing together moves
  // straight to WR_B.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    memop_d   = memop_q;
    wen_d     = wen_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    aw_fire   = (state_q == WR_AW) && !aw_done_q && bus.AWREADY;
    w_fire    = (state_q == WR_AW) && !w_done_q && bus.WREADY;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d    = bus.req_addr;
          wdata_d   = bus.req_wdata;
          memop_d   = bus.req_memop;
          wen_d     = bus.req_wen;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          err_d     = 1'b0;
          rdata_d   = '0;
`ifdef LSU_MISALIGN_CHECK_EN
          if (misaligned) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if (bus.req_wen) begin
            state_d = WR_AW;
          end else begin
            state_d = RD_A;
          end
`else
          if (bus.req_wen) begin
            state_d = WR_AW;
          end else begin
            state_d = RD_A;
          end
`endif
        end
      end
      RD_A: begin
        if (bus.ARREADY) begin
          state_d = RD_D;
        end
      end
      RD_D: begin
        if (bus.RVALID) begin
          rdata_d = load_ext;
          err_d   = (bus.RRESP != 2'b00);
          state_d = RESP;
        end
      end
      WR_AW: begin
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
          state_d = WR_B;
        end
      end
      WR_B: begin
        if (bus.BVALID) begin
          err_d   = (bus.BRESP != 2'b00);
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are pure functions of state and registers; address/data are
  // held steady from registers so they cannot change while VALID is high.
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.ARVALID    = (state_q == RD_A);
    bus.ARADDR     = {addr_q[63:3], 3'b000};
    bus.RREADY     = (state_q == RD_D);
    bus.AWVALID    = (state_q == WR_AW) && !aw_done_q;
    bus.AWADDR     = {addr_q[63:3], 3'b000};
    bus.WVALID     = (state_q == WR_AW) && !w_done_q;
    bus.WDATA      = wdata_q << {addr_q[2:0], 3'b000};
    bus.WSTRB      = strb_base << addr_q[2:0];
    bus.BREADY     = (state_q == WR_B);
    bus.resp_valid = (state_q == RESP);
    bus.resp_err   = (state_q == RESP) && err_q;
    bus.resp_rdata = ((state_q == RESP) && !wen_q) ? rdata_q : 64'd0;
  end

endmodule

// File: tb/tb_lsu_axi.sv
// tb_lsu_axi -- randomized self-checking bench for lsu_axi.
//
// The bench plays the execute stage and an AXI-lite slave with per-channel
// wait states, and compares every completion against a byte-level model of
// the load/store rules. Build with LSU_MISALIGN_CHECK_EN to exercise the
// misalignment trap.
`timescale 1ns/1ps
module tb_lsu_axi;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_axi_if bus_if ();

  lsu_axi dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int total = 0;
  int bad   = 0;

  // Values captured during the most recent transaction, for directed checks.
  logic [63:0] last_rdata;
  logic        last_err;
  logic [63:0] last_wdata;
  logic [7:0]  last_strb;
  int          last_lat;

  // Single comparison point: counts and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%016h want=0x%016h", tag, got, exp);
    end
  endtask

  // Access width in bytes from the size field.
  function automatic int access_bytes(input logic [2:0] memop);
    return 1 << memop[1:0];
  endfunction

  function automatic bit model_misaligned(input logic [2:0] memop, input logic [63:0] addr);
    return (int'(addr[2:0]) % access_bytes(memop)) != 0;
  endfunction

  // Byte lanes touched: lanes off..off+n-1 that fall inside the doubleword.
  function automatic logic [7:0] model_strb(input logic [2:0] memop, input logic [63:0] addr);
    logic [7:0] s = '0;
    int off = int'(addr[2:0]);
    for (int i = 0; i < 8; i++)
      if (i >= off && i < off + access_bytes(memop)) s[i] = 1'b1;
    return s;
  endfunction

  // Store data moved up so its byte 0 lands on lane 'off'.
  function automatic logic [63:0] model_wdata(input logic [63:0] data, input logic [63:0] addr);
    logic [63:0] w = '0;
    int off = int'(addr[2:0]);
    for (int i = 0; i < 8; i++)
      if (i >= off) w[8*i +: 8] = data[8*(i-off) +: 8];
    return w;
  endfunction

  // Load result: gather the accessed bytes, then extend from the access size.
  function automatic logic [63:0] model_load(input logic [63:0] data, input logic [2:0] memop,
                                             input logic [63:0] addr);
    logic [63:0] r = '0;
    int off = int'(addr[2:0]);
    int n = access_bytes(memop);
    for (int i = 0; i < 8; i++)
      if (i < n && off + i < 8) r[8*i +: 8] = data[8*(off+i) +: 8];
    if (!memop[2] && n < 8 && r[8*n-1])
      for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic clearSlave();
    bus_if.AWREADY = 1'b0;
    bus_if.WREADY  = 1'b0;
    bus_if.BVALID  = 1'b0;
    bus_if.BRESP   = 2'b00;
    bus_if.ARREADY = 1'b0;
    bus_if.RVALID  = 1'b0;
    bus_if.RRESP   = 2'b00;
    bus_if.RDATA   = '0;
  endtask

  // One complete transaction. dly_a delays ARREADY/AWREADY, dly_w delays
  // WREADY, dly_d delays RVALID/BVALID, each counted in cycles the DUT has
  // been waiting on that channel.
  task automatic applyStimulus(input logic wen, input logic [2:0] memop, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [63:0] rdata,
                               input logic [1:0] code, input int dly_a, input int dly_w,
                               input int dly_d);
    int ar_hs = 0, aw_hs = 0, w_hs = 0;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, d_cnt = 0;
    bit ar_pend = 0, aw_pend = 0, w_pend = 0;
    bit got_resp = 0;
    bit skip;
    int lat = 0;
    int exp_lat;
    logic [63:0] got_rdata = '0;
    logic        got_err = 1'b0;
    logic [63:0] got_wdata = '0, got_araddr = '0, got_awaddr = '0;
    logic [7:0]  got_strb = '0;
    logic [63:0] exp_rdata;
`ifdef LSU_MISALIGN_CHECK_EN
    skip = model_misaligned(memop, addr);
`else
    skip = 1'b0;
`endif

    @(negedge clk);
    checkOutput("ready_idle", 64'(bus_if.req_ready), 64'd1);
    bus_if.req_valid = 1'b1;
    bus_if.req_wen   = wen;
    bus_if.req_memop = memop;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = wdata;
    @(negedge clk);
    bus_if.req_valid = 1'b0;

    for (int n = 1; n <= 60; n++) begin
      clearSlave();
      if (bus_if.resp_valid) begin
        got_resp  = 1;
        lat       = n;
        got_rdata = bus_if.resp_rdata;
        got_err   = bus_if.resp_err;
        break;
      end
      if (ar_pend) checkOutput("ar_hold", 64'(bus_if.ARVALID), 64'd1);
      if (aw_pend) checkOutput("aw_hold", 64'(bus_if.AWVALID), 64'd1);
      if (w_pend)  checkOutput("w_hold",  64'(bus_if.WVALID),  64'd1);
      ar_pend = 0; aw_pend = 0; w_pend = 0;
      if (bus_if.ARVALID) begin
        if (ar_cnt >= dly_a) begin
          bus_if.ARREADY = 1'b1; ar_hs++; got_araddr = bus_if.ARADDR;
        end else ar_pend = 1;
        ar_cnt++;
      end
      if (bus_if.RREADY) begin
        if (d_cnt >= dly_d) begin
          bus_if.RVALID = 1'b1; bus_if.RDATA = rdata; bus_if.RRESP = code;
        end
        d_cnt++;
      end
      if (bus_if.AWVALID) begin
        if (aw_cnt >= dly_a) begin
          bus_if.AWREADY = 1'b1; aw_hs++; got_awaddr = bus_if.AWADDR;
        end else aw_pend = 1;
        aw_cnt++;
      end
      if (bus_if.WVALID) begin
        if (w_cnt >= dly_w) begin
          bus_if.WREADY = 1'b1; w_hs++; got_wdata = bus_if.WDATA; got_strb = bus_if.WSTRB;
        end else w_pend = 1;
        w_cnt++;
      end
      if (bus_if.BREADY) begin
        if (d_cnt >= dly_d) begin
          bus_if.BVALID = 1'b1; bus_if.BRESP = code;
        end
        d_cnt++;
      end
      @(negedge clk);
    end
    clearSlave();

    checkOutput("resp_seen", 64'(got_resp), 64'd1);
    if (skip)      exp_lat = 1;
    else if (wen)  exp_lat = 3 + ((dly_a > dly_w) ? dly_a : dly_w) + dly_d;
    else           exp_lat = 3 + dly_a + dly_d;
    checkOutput("latency", 64'(lat), 64'(exp_lat));

    exp_rdata = (skip || wen) ? 64'd0 : model_load(rdata, memop, addr);
    checkOutput("rdata", got_rdata, exp_rdata);
    checkOutput("err", 64'(got_err), skip ? 64'd1 : 64'(code != 2'b00));
    checkOutput("ar_count", 64'(ar_hs), (skip || wen) ? 64'd0 : 64'd1);
    checkOutput("aw_count", 64'(aw_hs), (skip || !wen) ? 64'd0 : 64'd1);
    checkOutput("w_count",  64'(w_hs),  (skip || !wen) ? 64'd0 : 64'd1);
    if (!skip && !wen) checkOutput("araddr", got_araddr, {addr[63:3], 3'b000});
    if (!skip && wen) begin
      checkOutput("awaddr", got_awaddr, {addr[63:3], 3'b000});
      checkOutput("wstrb", 64'(got_strb), 64'(model_strb(memop, addr)));
      checkOutput("wdata", got_wdata, model_wdata(wdata, addr));
    end

    last_rdata = got_rdata;
    last_err   = got_err;
    last_wdata = got_wdata;
    last_strb  = got_strb;
    last_lat   = lat;

    @(negedge clk);
    checkOutput("single_pulse", 64'(bus_if.resp_valid), 64'd0);
    checkOutput("ready_back", 64'(bus_if.req_ready), 64'd1);
  endtask

  // Start a load, hold off RVALID, and reset while the unit waits in RD_D.
  task automatic resetMidRead();
    int seen = 0;
    @(negedge clk);
    bus_if.req_valid = 1'b1;
    bus_if.req_wen   = 1'b0;
    bus_if.req_memop = 3'b011;
    bus_if.req_addr  = 64'h8000_0040;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      clearSlave();
      if (bus_if.RREADY) break;
      bus_if.ARREADY = bus_if.ARVALID;
      @(negedge clk);
    end
    clearSlave();
    checkOutput("rst_in_rd_d", 64'(bus_if.RREADY), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_arvalid", 64'(bus_if.ARVALID), 64'd0);
    checkOutput("rst_rready", 64'(bus_if.RREADY), 64'd0);
    checkOutput("rst_req_ready", 64'(bus_if.req_ready), 64'd1);
    bus_if.RVALID = 1'b1;
    bus_if.RDATA  = 64'hDEAD_BEEF_0000_0001;
    for (int n = 0; n < 5; n++) begin
      if (bus_if.resp_valid) seen++;
      @(negedge clk);
    end
    clearSlave();
    checkOutput("rst_no_resp", 64'(seen), 64'd0);
  endtask

  initial begin
    logic [63:0] rd;
    logic        wen;
    logic [2:0]  memop;
    logic [1:0]  code;

    rst = 1'b1;
    bus_if.req_valid = 1'b0;
    bus_if.req_wen   = 1'b0;
    bus_if.req_memop = 3'b000;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;
    clearSlave();
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", 64'(bus_if.req_ready), 64'd1);
    checkOutput("reset_arvalid", 64'(bus_if.ARVALID), 64'd0);
    checkOutput("reset_awvalid", 64'(bus_if.AWVALID), 64'd0);
    checkOutput("reset_wvalid", 64'(bus_if.WVALID), 64'd0);
    checkOutput("reset_rready", 64'(bus_if.RREADY), 64'd0);
    checkOutput("reset_bready", 64'(bus_if.BREADY), 64'd0);
    checkOutput("reset_resp_valid", 64'(bus_if.resp_valid), 64'd0);
    checkOutput("reset_resp_err", 64'(bus_if.resp_err), 64'd0);
    checkOutput("reset_resp_rdata", bus_if.resp_rdata, 64'd0);
    rst = 1'b0;

    $display("[TB] directed cases");
    applyStimulus(1'b0, 3'b011, 64'h8000_0008, 64'd0, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0);
    checkOutput("ld_lat3", 64'(last_lat), 64'd3);
    checkOutput("ld_data", last_rdata, 64'h1122_3344_5566_7788);

    rd = 64'h0102_0304_8011_2233;
    applyStimulus(1'b0, 3'b000, 64'h8000_0003, 64'd0, rd, 2'b00, 0, 0, 0);
    checkOutput("lb_sext", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    applyStimulus(1'b0, 3'b100, 64'h8000_0003, 64'd0, rd, 2'b00, 1, 0, 2);
    checkOutput("lbu_zext", last_rdata, 64'h0000_0000_0000_0080);

    applyStimulus(1'b1, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 64'd0, 2'b00, 2, 0, 0);
    checkOutput("sh_strb", 64'(last_strb), 64'h0000_0000_0000_00C0);
    checkOutput("sh_wdata_top", 64'(last_wdata[63:48]), 64'h0000_0000_0000_BEEF);

    applyStimulus(1'b1, 3'b010, 64'h8000_0010, 64'h1234_5678, 64'd0, 2'b10, 0, 1, 1);
    checkOutput("sw_bresp_err", 64'(last_err), 64'd1);

    applyStimulus(1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'hCAFE_F00D_8765_4321, 2'b00, 0, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    checkOutput("lw_mis_lat", 64'(last_lat), 64'd1);
`endif

    resetMidRead();

    $display("[TB] random cases");
    for (int t = 0; t < 60; t++) begin
      wen   = 1'($urandom_range(0, 1));
      memop = wen ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      code  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      applyStimulus(wen, memop, 64'h8000_0000 + 64'($urandom_range(0, 255)),
                    {$urandom, $urandom}, {$urandom, $urandom}, code,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
